// File: rtl/debug_trace_unit.sv
// Trace monitor for the FFT128 core: detects configurable trigger events and queues
// fixed-length trace records into a FIFO that drains over a valid/ready port.
module debug_trace_unit #(
    parameter int unsigned NB       = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CFG_BASE = 16,
    parameter int unsigned OVF_W    = 8
) (
    input  logic          clk,
    input  logic          MRST,
    input  logic          START,
    input  logic          RDY,
    input  logic          OVF1,
    input  logic          OVF2,
    input  logic [NB-1:0] DR,
    input  logic [NB-1:0] DI,
    input  logic [NB+3:0] DOR,
    input  logic [NB+3:0] DOI,
    input  logic [6:0]    ADDR,
    input  logic [31:0]   DCP,
    input  logic [1:0]    Sel,
    input  logic          TREADY,
    output logic [31:0]   TP,
    output logic          TPE,
    output logic [7:0]    EV,
    output logic [31:0]   Val,
    output logic [15:0]   DROPS
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;
    state_e state_q, state_d;

    // Configuration bus: index latched in one cycle, data written the next.
    logic [7:0]  idx_q;
    logic [1:0]  sel_q;
    logic        wr_pend_q;
    logic [31:0] cfr_q [4];
    logic [31:0] cfg_off;
    assign cfg_off = 32'(idx_q) - 32'(CFG_BASE);

    always_ff @(posedge clk) begin
        if (MRST) begin
            idx_q     <= 8'hFF;
            sel_q     <= 2'b00;
            wr_pend_q <= 1'b0;
            for (int i = 0; i < 4; i++) cfr_q[i] <= '0;
        end else begin
            wr_pend_q <= DCP[31];
            if (DCP[31]) begin
                idx_q <= DCP[7:0];
                sel_q <= Sel;
            end
            if (wr_pend_q && cfg_off < 32'd4) cfr_q[cfg_off[1:0]] <= DCP;
        end
    end

    logic [7:0]       mode;
    logic             snap_en;
    logic [OVF_W-1:0] ovf_thr;
    logic [31:0]      cyc_lim;
    logic             unused_cfg;
    assign mode       = cfr_q[0][7:0];
    assign snap_en    = cfr_q[0][8];
    assign ovf_thr    = cfr_q[1][OVF_W-1:0];
    assign cyc_lim    = cfr_q[2];
    assign unused_cfg = ^{cfr_q[3], cfr_q[0][31:9], cfr_q[1][31:OVF_W]};

    // Frame tracking and performance/overflow counters.
    logic             start_q, rdy_q, active_q, ovf_hit_q, perf_hit_q;
    logic [31:0]      perf_q;
    logic [OVF_W-1:0] ovfcnt_q;
    logic             start_fall, rdy_rise, ovf_cond, perf_cond;
    assign start_fall = start_q & ~START;
    assign rdy_rise   = RDY & ~rdy_q;
    assign ovf_cond   = (ovfcnt_q > ovf_thr) && !ovf_hit_q;
    assign perf_cond  = active_q && (perf_q > cyc_lim) && !perf_hit_q;

    always_ff @(posedge clk) begin
        if (MRST) begin
            start_q    <= 1'b0;
            rdy_q      <= 1'b0;
            active_q   <= 1'b0;
            ovf_hit_q  <= 1'b0;
            perf_hit_q <= 1'b0;
            perf_q     <= '0;
            ovfcnt_q   <= '0;
        end else begin
            start_q <= START;
            rdy_q   <= RDY;
            if (start_fall) begin
                perf_q     <= 32'd1;
                active_q   <= 1'b1;
                ovfcnt_q   <= '0;
                ovf_hit_q  <= 1'b0;
                perf_hit_q <= 1'b0;
            end else begin
                if (active_q) begin
                    if (RDY) active_q <= 1'b0;
                    else if (perf_q != '1) perf_q <= perf_q + 32'd1;
                end
                if (OVF1 && ovfcnt_q != '1) ovfcnt_q <= ovfcnt_q + 1'b1;
                if (ovf_cond) ovf_hit_q <= 1'b1;
                if (perf_cond) perf_hit_q <= 1'b1;
            end
        end
    end

    // Trigger decode, record length and first word.
    logic        trig;
    logic [2:0]  len;
    logic [31:0] word0;
    always_comb begin
        trig  = 1'b0;
        len   = 3'd1;
        word0 = perf_q;
        case (mode)
            8'd1: trig = rdy_rise;
            8'd2: begin trig = start_fall; word0 = 32'({DI, DR}); end
            8'd3: begin trig = rdy_rise; len = 3'd4; end
            8'd4: begin trig = rdy_rise; len = 3'd6; word0 = 32'(ADDR); end
            8'd5: begin trig = OVF1 & OVF2; word0 = '1; end
            8'd6: begin trig = ovf_cond; word0 = 32'({ovfcnt_q, ADDR}); end
            8'd7: trig = perf_cond;
            default: ;
        endcase
    end

    logic [AW:0] cnt_q;
    logic        admit, drop, push, pop;
    assign admit = trig && (state_q == StIdle) && ((32'(cnt_q) + 32'(len)) <= DEPTH);
    assign drop  = trig && !admit;
    assign pop   = TPE & TREADY;

    // Record-in-flight state; layout is frozen at admission so CFR0 writes cannot alter it.
    logic [2:0]    k_q, rec_len_q;
    logic [NB+3:0] snap_dor_q, snap_doi_q;
    logic [6:0]    snap_addr_q;
    logic [31:0]   emit_word, wdata;

    always_ff @(posedge clk) begin
        if (MRST) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (admit && len > 3'd1) state_d = StEmit;
            StEmit: if (k_q == rec_len_q - 3'd1) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        emit_word = 32'(snap_addr_q);
        if (rec_len_q == 3'd6)  emit_word = 32'(ADDR);
        else if (k_q == 3'd1)   emit_word = 32'(snap_dor_q);
        else if (k_q == 3'd2)   emit_word = 32'(snap_doi_q);
    end

    always_comb begin
        push  = 1'b0;
        wdata = word0;
        case (state_q)
            StIdle: push = admit;
            StEmit: begin push = 1'b1; wdata = emit_word; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (MRST) begin
            k_q         <= '0;
            rec_len_q   <= 3'd1;
            snap_dor_q  <= '0;
            snap_doi_q  <= '0;
            snap_addr_q <= '0;
        end else if (state_q == StIdle) begin
            if (admit) begin
                k_q         <= 3'd1;
                rec_len_q   <= len;
                snap_dor_q  <= DOR;
                snap_doi_q  <= DOI;
                snap_addr_q <= ADDR;
            end
        end else begin
            k_q <= k_q + 3'd1;
        end
    end

    // Trace FIFO.
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (MRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign TPE = (cnt_q != '0);
    assign TP  = TPE ? mem_q[rd_ptr_q] : '0;

    // Snapshot and drop accounting.
    logic [7:0]  ev_q;
    logic [31:0] val_q;
    logic [15:0] drops_q;

    always_ff @(posedge clk) begin
        if (MRST) begin
            ev_q    <= '0;
            val_q   <= '0;
            drops_q <= '0;
        end else begin
            if (!snap_en) begin
                ev_q <= '0;
            end else if (sel_q == 2'b11 && admit) begin
                ev_q  <= mode;
                val_q <= 32'({DI, DR});
            end
            if (drop && drops_q != 16'hFFFF) drops_q <= drops_q + 16'd1;
        end
    end

    assign EV    = ev_q;
    assign Val   = val_q;
    assign DROPS = drops_q;
endmodule

// File: tb/tb_debug_trace_unit.sv
// Directed bench for debug_trace_unit: expected trace words go into a queue and a
// negedge monitor checks every word the DUT hands over.
module tb_debug_trace_unit;
    logic        clk = 1'b0;
    logic        MRST, START, RDY, OVF1, OVF2, TREADY;
    logic [15:0] DR, DI;
    logic [19:0] DOR, DOI;
    logic [6:0]  ADDR;
    logic [31:0] DCP;
    logic [1:0]  Sel;
    logic [31:0] TP, Val;
    logic        TPE;
    logic [7:0]  EV;
    logic [15:0] DROPS;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q [$];

    debug_trace_unit #(.NB(16), .DEPTH(8), .CFG_BASE(16), .OVF_W(8)) dut (
        .clk(clk), .MRST(MRST), .START(START), .RDY(RDY), .OVF1(OVF1), .OVF2(OVF2),
        .DR(DR), .DI(DI), .DOR(DOR), .DOI(DOI), .ADDR(ADDR), .DCP(DCP), .Sel(Sel),
        .TREADY(TREADY), .TP(TP), .TPE(TPE), .EV(EV), .Val(Val), .DROPS(DROPS)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: a word is consumed on the next rising edge when TPE & TREADY.
    always @(negedge clk) begin
        if (!MRST && TPE && TREADY) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %h expected none", TP);
            end else begin
                check("trace_word", TP, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [7:0] idx, input logic [31:0] data,
                             input logic [1:0] sel);
        DCP = {24'h800000, idx};
        Sel = sel;
        tick(1);
        DCP = data;
        Sel = 2'b00;
        tick(1);
        DCP = '0;
    endtask

    initial begin
        MRST = 1'b1; START = 1'b0; RDY = 1'b0; OVF1 = 1'b0; OVF2 = 1'b0;
        TREADY = 1'b0; DR = '0; DI = '0; DOR = '0; DOI = '0; ADDR = '0;
        DCP = '0; Sel = 2'b00;
        tick(2);
        check("reset_tpe", 32'(TPE), 32'd0);
        check("reset_tp", TP, 32'd0);
        check("reset_ev", 32'(EV), 32'd0);
        check("reset_val", Val, 32'd0);
        check("reset_drops", 32'(DROPS), 32'd0);
        MRST = 1'b0;
        tick(1);

        // Mode 1: perfcoun at RDY rise after 50 cycles of RDY=0.
        cfg_write(8'd16, 32'd1, 2'b00);
        START = 1'b1; tick(1);
        START = 1'b0; tick(50);
        RDY = 1'b1;
        exp_q.push_back(32'd50);
        check("m1_tpe_at_t", 32'(TPE), 32'd0);
        tick(1);
        check("m1_tpe_next", 32'(TPE), 32'd1);
        check("m1_tp_next", TP, 32'd50);
        RDY = 1'b0; START = 1'b1; TREADY = 1'b1;
        tick(3);

        // Mode 3: four-word snapshot record.
        cfg_write(8'd16, 32'd3, 2'b00);
        START = 1'b0; tick(10);
        RDY = 1'b1; DOR = 20'h12345; DOI = 20'hABCDE; ADDR = 7'h55;
        exp_q.push_back(32'd10);
        exp_q.push_back(32'h00012345);
        exp_q.push_back(32'h000ABCDE);
        exp_q.push_back(32'h00000055);
        tick(1);
        RDY = 1'b0; DOR = 20'h0; DOI = 20'h0; ADDR = 7'h01; START = 1'b1;
        tick(8);
        check("m3_drained", 32'(exp_q.size()), 32'd0);

        // Mode 4 under backpressure: second record dropped.
        TREADY = 1'b0;
        cfg_write(8'd16, 32'd4, 2'b00);
        START = 1'b0; tick(2);
        for (int k = 0; k < 6; k++) begin
            ADDR = 7'(8'h10 + k);
            if (k == 0) RDY = 1'b1;
            exp_q.push_back(32'(8'h10 + k));
            tick(1);
        end
        RDY = 1'b0; START = 1'b1; tick(1);
        START = 1'b0; tick(1);
        RDY = 1'b1; tick(1);
        RDY = 1'b0; tick(3);
        check("m4_drops", 32'(DROPS), 32'd1);
        check("m4_tpe_stall", 32'(TPE), 32'd1);
        check("m4_tp_stall", TP, 32'h10);
        TREADY = 1'b1;
        tick(10);
        check("m4_tpe_empty", 32'(TPE), 32'd0);
        check("m4_drained", 32'(exp_q.size()), 32'd0);

        // Mode 6: one record when ovfcnt first exceeds 3.
        cfg_write(8'd17, 32'd3, 2'b00);
        cfg_write(8'd16, 32'd6, 2'b00);
        START = 1'b1; tick(1);
        START = 1'b0; ADDR = 7'h2A; tick(1);
        exp_q.push_back(32'h0000022A);
        for (int p = 0; p < 7; p++) begin
            OVF1 = 1'b1; tick(1);
            OVF1 = 1'b0; tick(1);
        end
        RDY = 1'b1; tick(1);
        RDY = 1'b0; tick(3);
        check("m6_single", 32'(exp_q.size()), 32'd0);

        // Mode 5 with EV/Val snapshot enabled, then disabled.
        cfg_write(8'd16, 32'h105, 2'b11);
        DI = 16'hBEEF; DR = 16'h1234; OVF1 = 1'b1; OVF2 = 1'b1;
        exp_q.push_back(32'hFFFFFFFF);
        tick(1);
        OVF1 = 1'b0; OVF2 = 1'b0; DI = '0; DR = '0;
        check("m5_ev", 32'(EV), 32'd5);
        check("m5_val", Val, 32'hBEEF1234);
        cfg_write(8'd16, 32'd5, 2'b00);
        tick(1);
        check("ev_cleared", 32'(EV), 32'd0);
        check("val_held", Val, 32'hBEEF1234);

        // Config bus: CFR2=255 via index 0x12; index 0x20 must be ignored.
        cfg_write(8'h12, 32'h000000FF, 2'b00);
        cfg_write(8'd16, 32'd7, 2'b00);
        for (int f = 0; f < 2; f++) begin
            START = 1'b1; tick(1);
            START = 1'b0;
            exp_q.push_back(32'd256);
            tick(300);
            RDY = 1'b1; tick(1);
            RDY = 1'b0; START = 1'b1; tick(2);
            check("m7_frame", 32'(exp_q.size()), 32'd0);
            if (f == 0) cfg_write(8'h20, 32'd10, 2'b00);
        end
        check("drops_pre_reset", 32'(DROPS), 32'd1);

        // Reset during a mode-4 record.
        cfg_write(8'd16, 32'd4, 2'b00);
        TREADY = 1'b0;
        START = 1'b0; tick(1);
        RDY = 1'b1; ADDR = 7'h33; tick(2);
        MRST = 1'b1; tick(1);
        check("rst_tpe", 32'(TPE), 32'd0);
        check("rst_drops", 32'(DROPS), 32'd0);
        MRST = 1'b0; RDY = 1'b0; tick(1);
        TREADY = 1'b1;
        START = 1'b1; tick(1);
        START = 1'b0; tick(2);
        RDY = 1'b1; tick(1);
        RDY = 1'b0; tick(5);
        check("post_rst_tpe", 32'(TPE), 32'd0);
        check("post_rst_drops", 32'(DROPS), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/debug_trace_unit.md
# debug_trace_unit

Parametrised second-generation debug monitor for the FFT128 core. It sits beside the FFT and watches its handshake (START/RDY), overflow flags, input samples and output port. It detects configurable trigger events and emits fixed-length trace records into an internal FIFO, which drains to the trace network over a valid/ready port. Configuration arrives over the shared DCP debug-configuration bus; EV/Val give a snapshot path to the wrapper.

## Interface
- NB, 16: FFT sample width; 2*NB ≤ 32.
- DEPTH, 8: trace FIFO entries; power of 2, ≥ 8.
- CFG_BASE, 16: first DCP configuration index owned by this block; four consecutive indices are used.
- OVF_W, 8: overflow-counter width; ≤ 24.

Ports:
- clk  in  1  sole clock, rising edge.
- MRST  in  1  reset; synchronous, active-high.
- START  in  1  FFT start; the falling edge begins a frame.
- RDY  in  1  FFT result ready; ends a frame.
- OVF1, OVF2  in  1 each  FFT overflow flags.
- DR, DI  in  NB each  FFT input sample, real and imaginary.
- DOR, DOI  in  NB+4 each  FFT output, real and imaginary.
- ADDR  in  7  FFT output address.
- DCP  in  32  debug-configuration bus.
- Sel  in  2  wrapper select; 2'b11 means the wrapper owns EV/Val.
- TREADY  in  1  trace sink ready.
- TP  out  32  trace word.
- TPE  out  1  trace word valid (FIFO not empty).
- EV  out  8  last event code (snapshot).
- Val  out  32  {DI,DR}, zero-extended, at the last event.
- DROPS  out  16  count of dropped records; saturates at 16'hFFFF.

## Operation
- **Configuration write**
  - When DCP[31]=1 in cycle A, the block latches idx=DCP[7:0] and Sel.
  - In cycle A+1, the full DCP value is written to CFR[idx-CFG_BASE] if CFG_BASE ≤ idx ≤ CFG_BASE+3. Other indices are ignored.
  - If DCP[31]=1 again in A+1, both the write and a new index latch happen.
- **Configuration registers**
  - CFR0[7:0]: mode.
  - CFR0[8]: enables the EV/Val snapshot.
  - CFR1[OVF_W-1:0]: overflow threshold.
  - CFR2: cycle limit.
  - CFR3: reserved; reads back only.
- **perfcoun (32 bits)**
  - Set to 1 on the START falling edge (START1=1, START=0).
  - Increments each cycle while active and RDY=0; saturates at 32'hFFFFFFFF.
  - On RDY=1, active clears and the value is held until the next frame.
- **ovfcnt (OVF_W bits)**
  - Increments on OVF1=1 and saturates.
  - Clears on the START falling edge. RDY does not clear it.
- **Triggers**, by mode (combinational, cycle T):
  - 1: RDY rising edge.
  - 2: START falling edge.
  - 3: RDY rising edge.
  - 4: RDY rising edge.
  - 5: OVF1 & OVF2.
  - 6: ovfcnt first exceeds CFR1 in this frame (once per frame).
  - 7: perfcoun first exceeds CFR2 while active (once per frame).
  - 0 or other values: no trigger.
- **Records.** Length L in words; all fields are zero-extended.
  - Mode 1: perfcoun (L=1).
  - Mode 2: {DI,DR} (L=1).
  - Mode 3: perfcoun, DOR, DOI, ADDR (L=4). All fields are snapshotted at T.
  - Mode 4: six ADDR samples taken live at cycles T..T+5 (L=6).
  - Mode 5: 32'hFFFFFFFF (L=1).
  - Mode 6: {ovfcnt, ADDR} packed with ADDR in [6:0] (L=1).
  - Mode 7: perfcoun (L=1).
- **Sequencer** has two states, IDLE and EMIT.
  - In IDLE, a trigger is admitted only if free FIFO slots ≥ L. Free slots are counted excluding a same-cycle pop.
  - An admitted trigger writes word 0 at the end of T. If L>1, the sequencer enters EMIT and writes word k at the end of T+k, returning to IDLE after word L-1.
  - A trigger that is not admitted, or that occurs during EMIT, is dropped whole and increments DROPS. Records are never split.
- **Mode change** (CFR0 write) during EMIT: the in-flight record completes with its original layout. The FIFO is never flushed by configuration.
- **EV/Val**
  - When CFR0[8]=1 and Sel=2'b11 is latched: on an admitted trigger, EV ← mode code and Val ← {DI,DR}. Otherwise EV and Val hold.
  - When CFR0[8]=0, EV ← 0.

## Timing
- **Reset values:** TP=0, TPE=0, EV=0, Val=0, DROPS=0. The FIFO is empty, all CFR are 0, perfcoun=0, ovfcnt=0, the sequencer is in IDLE, and the latched idx=8'hFF.
- **Reset mid-record:** the record is abandoned and the FIFO emptied. It takes effect at the next edge.
- **Latency:** trigger in cycle T gives TPE=1 at the earliest in T+1, with TP equal to word 0 (FIFO head is registered).
- **Handshake:** a word pops on an edge where TPE & TREADY. TP is stable while TPE=1 and TREADY=0.
- **Simultaneous push and pop when full:** the pop proceeds. A push in that cycle happens only as part of an already-admitted record.
- **Configuration latency:** a write in cycle A+1 affects triggers from A+2 onward.

## Test plan
- **Mode 1.** CFR0=1; START 1→0; hold RDY=0 for 50 cycles, then RDY=1 → one word TP=50, TPE=1 at the cycle after RDY rises.
- **Mode 3.** CFR0=3; at the RDY rise, DOR=20'h12345, DOI=20'hABCDE, ADDR=7'h55 → the four words perfcoun, 0x00012345, 0x000ABCDE, 0x00000055 arrive in order, with TREADY=1 throughout.
- **Backpressure and drop.** CFR0=4; TREADY=0; two frames → the first six ADDR words are stored and the second record is dropped (DROPS=1). Raise TREADY → exactly six words drain, then TPE=0.
- **Mode 6.** CFR1=3; four OVF1 pulses within one frame → exactly one record {ovfcnt=4, ADDR}; further pulses in the same frame give no new records.
- **Configuration bus.** DCP=0x80000012, then 0x000000FF → CFR2=255. DCP=0x80000020, then data → no register changes.
- **Reset during EMIT.** Assert MRST in mode-4 word 2 → the next cycle shows TPE=0 and DROPS=0; post-reset triggers are ignored while CFR0=0.
